// File: rtl/ux607_uartrx_ctrl_pkg.sv
// UART RX controller shared definitions: register map, field positions,
// FIFO depth and DIV reset value.
package ux607_uartrx_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_RXCTRL = 2'd0,
    ADDR_DIV    = 2'd1,
    ADDR_RXDATA = 2'd2,
    ADDR_IEIP   = 2'd3
  } reg_addr_e;

  localparam int unsigned FIFO_DEPTH       = 8;
  localparam logic [15:0] DIV_RESET        = 16'h021F;

  localparam int unsigned RXCTRL_RXEN_BIT  = 0;
  localparam int unsigned RXCTRL_RXCNT_LSB = 16;
  localparam int unsigned IEIP_RXWM_BIT    = 1;
  localparam int unsigned IEIP_OVR_BIT     = 2;

  localparam logic [31:0] RXDATA_EMPTY     = 32'h8000_0000;

endpackage

// File: rtl/ux607_uartrx_fifo.sv
// 8-entry receive byte FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise the byte is reported as dropped.
module ux607_uartrx_fifo
  import ux607_uartrx_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] head_data,
  output logic [3:0] count,
  output logic       drop
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       pop_fire;
  logic       push_fire;
  logic       full;

  assign full      = (count == 4'(FIFO_DEPTH));
  assign pop_fire  = pop_req && (count != 4'd0);
  assign push_fire = push_valid && (!full || pop_fire);
  assign drop      = push_valid && !push_fire;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; 3-bit pointers wrap 7->0 naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 3'd1;
      if (pop_fire)  rd_ptr <= rd_ptr + 3'd1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reset pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ux607_uartrx_ctrl.sv
// UART RX controller: register decode, receive FIFO and watermark interrupt.
// Optional overrun detection is built when UX607_UARTRX_OVERRUN_EN is defined.
module ux607_uartrx_ctrl
  import ux607_uartrx_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_wen,
  input  logic        reg_ren,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        rx_en,
  output logic [15:0] rx_div,
  input  logic        rx_valid,
  input  logic [7:0]  rx_bits,
  output logic        irq
);

  logic        rxen;
  logic [2:0]  rxcnt;
  logic [15:0] div;
  logic        rxwm_ie;
  logic        rxwm_ip;
  logic        ovr_ie;
  logic        ovr;
  logic [7:0]  fifo_head;
  logic [3:0]  fifo_count;
  logic        fifo_drop;
  logic        rxdata_rd;
  logic [31:0] rdata_next;

  assign rxdata_rd = reg_ren && (reg_addr == ADDR_RXDATA);
  assign rxwm_ip   = (fifo_count > {1'b0, rxcnt});
  assign rx_en     = rxen;
  assign rx_div    = div;
  assign irq       = (rxwm_ie && rxwm_ip) || (ovr_ie && ovr);

  ux607_uartrx_fifo u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (rx_valid),
    .push_data  (rx_bits),
    .pop_req    (rxdata_rd),
    .head_data  (fifo_head),
    .count      (fifo_count),
    .drop       (fifo_drop)
  );

  // Control register writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxen    <= 1'b0;
      rxcnt   <= '0;
      div     <= DIV_RESET;
      rxwm_ie <= 1'b0;
    end else if (reg_wen) begin
      case (reg_addr_e'(reg_addr))
        ADDR_RXCTRL: begin
          rxen  <= reg_wdata[RXCTRL_RXEN_BIT];
          rxcnt <= reg_wdata[RXCTRL_RXCNT_LSB +: 3];
        end
        ADDR_DIV:  div     <= reg_wdata[15:0];
        ADDR_IEIP: rxwm_ie <= reg_wdata[IEIP_RXWM_BIT];
        default:   ;
      endcase
    end
  end

`ifdef UX607_UARTRX_OVERRUN_EN
  // Overrun enable and sticky flag; a new drop wins over a same-cycle W1C.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovr_ie <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (reg_wen && (reg_addr == ADDR_IEIP)) ovr_ie <= reg_wdata[IEIP_OVR_BIT];
      if (fifo_drop)
        ovr <= 1'b1;
      else if (reg_wen && (reg_addr == ADDR_IEIP) && reg_wdata[IEIP_OVR_BIT])
        ovr <= 1'b0;
    end
  end
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:19];
`else
  assign ovr_ie = 1'b0;
  assign ovr    = 1'b0;
  logic unused_wdata;
  assign unused_wdata = ^{reg_wdata[31:19], fifo_drop};
`endif

  // Read data selection from the pre-edge state.
  always_comb begin
    rdata_next = '0;
    case (reg_addr_e'(reg_addr))
      ADDR_RXCTRL: begin
        rdata_next[RXCTRL_RXEN_BIT]         = rxen;
        rdata_next[RXCTRL_RXCNT_LSB +: 3]   = rxcnt;
      end
      ADDR_DIV:    rdata_next[15:0] = div;
      ADDR_RXDATA: rdata_next = (fifo_count == 4'd0) ? RXDATA_EMPTY : {24'd0, fifo_head};
      ADDR_IEIP: begin
        rdata_next[IEIP_RXWM_BIT] = rxwm_ip;
        rdata_next[IEIP_OVR_BIT]  = ovr;
      end
      default:     rdata_next = '0;
    endcase
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) reg_rdata <= '0;
    else if (reg_ren) reg_rdata <= rdata_next;
  end

endmodule

// File: doc/ux607_uartrx_ctrl.md
UX607_UARTRX_CTRL -- requirements
Module: ux607_uartrx_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port reg_wen, input, 1 bit: register write strobe, one write per cycle.
REQ-004 SHALL have port reg_ren, input, 1 bit: register read strobe.
REQ-005 SHALL have port reg_addr, input, 2 bits: 0=RXCTRL, 1=DIV, 2=RXDATA, 3=IE (write) / IP (read).
REQ-006 SHALL have port reg_wdata, input, 32 bits: write data.
REQ-007 SHALL have port reg_rdata, output, 32 bits: read data, registered.
REQ-008 SHALL have port rx_en, output, 1 bit: enable to the receiver datapath.
REQ-009 SHALL have port rx_div, output, 16 bits: baud divisor to the receiver.
REQ-010 SHALL have port rx_valid, input, 1 bit: one-cycle pulse, a received byte is present.
REQ-011 SHALL have port rx_bits, input, 8 bits: received byte, qualified by rx_valid.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-013 SHALL buffer received bytes in an 8-entry FIFO with 3-bit read/write pointers and a 4-bit count (0..8); pointers wrap 7->0.
REQ-014 SHALL push rx_bits when rx_valid=1 and (count<8 or a pop occurs in the same cycle); otherwise SHALL drop the byte.
REQ-015 SHALL pop on reg_ren=1 with reg_addr=2 and count>0; reg_rdata next cycle = {1'b0, 23'b0, head byte}.
REQ-016 SHALL, on an RXDATA read with count=0, return reg_rdata=32'h8000_0000 and leave pointers unchanged, including when a push occurs in the same cycle (the pushed byte is retained).
REQ-017 SHALL, on a simultaneous push and pop with 0<count<=8, leave count unchanged and advance both pointers.
REQ-018 SHALL map RXCTRL as bit0=rxen and bits[18:16]=rxcnt (watermark); read returns the same layout, other bits 0.
REQ-019 SHALL map DIV as bits[15:0]=div; rx_div=div and rx_en=rxen, driven directly from the registers.
REQ-020 SHALL map IE as bit1=rxwm_ie; IP read SHALL return bit1=rxwm_ip, where rxwm_ip = (count > rxcnt), combinational.
REQ-021 SHALL drive irq = rxwm_ie & rxwm_ip, plus the overrun term defined in REQ-027.
REQ-022 SHALL make a write take effect at the next clock edge; a read of any address other than RXDATA SHALL have no side effects.
REQ-023 SHALL retain FIFO contents when rxen is cleared; rx_valid pulses arriving while rxen=0 SHALL still be accepted.

Reset
REQ-024 SHALL reset asynchronously to: rxen=0, rxcnt=0, div=16'h021F, rxwm_ie=0, FIFO pointers and count=0, reg_rdata=0, irq=0.
REQ-025 SHALL discard all FIFO contents on a reset asserted mid-operation; the first push after deassertion SHALL land in entry 0.

Configuration
REQ-026 SHALL compile in overrun detection only when UX607_UARTRX_OVERRUN_EN is defined.
REQ-027 With the macro defined: a byte dropped under REQ-014 SHALL set a sticky ovr flag, visible as IP bit2; IE bit2 is ovr_ie; irq additionally ORs ovr_ie & ovr; ovr SHALL clear when IP is written with bit2=1 (W1C).
REQ-028 Without the macro: IP bit2 and IE bit2 SHALL read 0, and drops SHALL be silent.

Structure
REQ-029 SHALL place register address constants, field bit positions, FIFO depth (8) and the DIV reset value in the shared ux607 peripheral package.
REQ-030 SHALL implement the FIFO storage and pointers as a single sub-module, ux607_uartrx_fifo; register decode and the interrupt logic remain in the top-level module.

Verification
REQ-031 Verification SHALL cover reset: after reset, read DIV -> 32'h0000_021F; read RXCTRL -> 0; irq=0.
REQ-032 Verification SHALL cover ordering: push bytes 8'h41, 8'h42, 8'h43, then read RXDATA three times -> 8'h41, 8'h42, 8'h43; a fourth read -> 32'h8000_0000.
REQ-033 Verification SHALL cover the watermark: rxcnt=2 and rxwm_ie=1, push 3 bytes -> irq=1 after the 3rd push; one RXDATA pop -> irq=0.
REQ-034 Verification SHALL cover full with pop: push 8 bytes (count=8), then a 9th rx_valid in the same cycle as an RXDATA pop -> byte accepted, count stays 8, no drop.
REQ-035 Verification SHALL cover overrun (macro defined): with count=8, push 8'hFF and no pop -> IP bit2=1 and irq=1 with ovr_ie=1; write IP=32'h4 -> bit2=0.
REQ-036 Verification SHALL cover empty with push: with count=0, an RXDATA read in the same cycle as a push of 8'h5A -> read returns 32'h8000_0000; the next read returns 8'h5A.
